// File: rtl/pio_button_debounced.sv
// pio_button_debounced
//   Avalon-MM input PIO for push-buttons and switches. Each input bit is
//   synchronised (two flops), debounced with a per-bit counter, and edge
//   captured. Captured edges gated by an interrupt mask drive a level IRQ.
//
//   Optional build macro BUTTON_ACTIVE_LOW_EN: when defined, in_port is
//   inverted before the synchroniser so that a pressed active-low key reads
//   as 1 and a press is a rising edge. When undefined, in_port is used as is.
//
//   Register map (word address, all unused upper bits read 0):
//     0 data        RO   debounced value
//     1 raw         RO   synchronised, undebounced value
//     2 irqmask     RW   interrupt mask
//     3 edgecapture R/W1C captured edges (set wins over a same-cycle clear)
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   address    Avalon word address
//   chipselect slave select
//   write      write strobe, qualified by chipselect
//   writedata  write data
//   in_port    raw asynchronous button inputs
//   readdata   registered read data, updated every clock from address
//   irq        level interrupt, |(edgecapture & irqmask)
module pio_button_debounced #(
   parameter int unsigned WIDTH           = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned EDGE_TYPE       = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES + 1);
   // Accept on the edge where the counter would otherwise reach DEBOUNCE_CYCLES.
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);

   logic [WIDTH-1:0]           in_eff;
   logic [WIDTH-1:0]           sync1_q, sync1_d;
   logic [WIDTH-1:0]           sync2_q, sync2_d;
   logic [WIDTH-1:0]           stable_q, stable_d;
   logic [WIDTH-1:0][CntW-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]           mask_q, mask_d;
   logic [WIDTH-1:0]           cap_q, cap_d;
   logic [31:0]                readdata_q, readdata_d;

   logic [WIDTH-1:0]           rise, fall, cap_set, cap_clr;
   logic                       wr_en;

   // Only writedata[WIDTH-1:0] is meaningful; fold the rest away.
   logic                       unused_wdata;
   assign unused_wdata = ^writedata;

`ifdef BUTTON_ACTIVE_LOW_EN
   assign in_eff = ~in_port;
`else
   assign in_eff = in_port;
`endif

   always_comb begin
      sync1_d  = in_eff;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      cnt_d    = cnt_q;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (sync2_q[i] == stable_q[i]) begin
            // Any return to the stable level rejects the pending change.
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CntLast) begin
            stable_d[i] = sync2_q[i];
            cnt_d[i]    = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
         end
      end
   end

   always_comb begin
      rise = stable_d & ~stable_q;
      fall = stable_q & ~stable_d;
      if (EDGE_TYPE == 0) begin
         cap_set = rise;
      end else if (EDGE_TYPE == 1) begin
         cap_set = fall;
      end else begin
         cap_set = rise | fall;
      end

      wr_en   = chipselect & write;
      cap_clr = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
      // Set is applied after the clear so a same-edge capture survives.
      cap_d   = (cap_q & ~cap_clr) | cap_set;
      mask_d  = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;
   end

   always_comb begin
      readdata_d = '0;
      unique case (address)
         2'd0:    readdata_d[WIDTH-1:0] = stable_q;
         2'd1:    readdata_d[WIDTH-1:0] = sync2_q;
         2'd2:    readdata_d[WIDTH-1:0] = mask_q;
         default: readdata_d[WIDTH-1:0] = cap_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         stable_q   <= '0;
         cnt_q      <= '0;
         mask_q     <= '0;
         cap_q      <= '0;
         readdata_q <= '0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         stable_q   <= stable_d;
         cnt_q      <= cnt_d;
         mask_q     <= mask_d;
         cap_q      <= cap_d;
         readdata_q <= readdata_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_pio_button_debounced.sv
// Testbench for pio_button_debounced. Three instances (rising, falling and
// any-edge capture) share one stimulus stream. A reference model pushes the
// expected readdata/irq of every instance on each clock; a monitor pops and
// compares on the falling edge.
module tb_pio_button_debounced;

   localparam int unsigned W = 4;
   localparam int unsigned D = 4;

`ifdef BUTTON_ACTIVE_LOW_EN
   localparam logic [W-1:0] Inv = '1;
`else
   localparam logic [W-1:0] Inv = '0;
`endif

   typedef struct packed {
      logic [2:0][31:0] rd;
      logic [2:0]       irq;
   } exp_t;

   logic          clk;
   logic          reset_n;
   logic [1:0]    address;
   logic          chipselect;
   logic          write;
   logic [31:0]   writedata;
   logic [W-1:0]  in_port;
   logic [2:0][31:0] readdata;
   logic [2:0]    irq;

   exp_t          exp_q[$];
   int            errors = 0;
   int            checks = 0;
   int            cyc    = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      pio_button_debounced #(
         .WIDTH           (W),
         .DEBOUNCE_CYCLES (D),
         .EDGE_TYPE       (g)
      ) dut (
         .clk        (clk),
         .reset_n    (reset_n),
         .address    (address),
         .chipselect (chipselect),
         .write      (write),
         .writedata  (writedata),
         .in_port    (in_port),
         .readdata   (readdata[g]),
         .irq        (irq[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Two-sample delay line for the synchroniser; a bit's debounced value
   // flips once its last D synchronised samples since the previous flip all
   // disagree with it.
   logic [W-1:0] m_p1, m_s, m_stable, m_mask;
   logic [W-1:0] m_cap[3];
   bit           win[W][$];

   always @(posedge clk) begin : model
      exp_t         e;
      logic [W-1:0] nstable, rise, fall, clr;
      bit           all_diff;
      e = '0;
      if (!reset_n) begin
         m_p1 = '0; m_s = '0; m_stable = '0; m_mask = '0;
         for (int t = 0; t < 3; t++) m_cap[t] = '0;
         for (int b = 0; b < int'(W); b++) win[b].delete();
      end else begin
         for (int t = 0; t < 3; t++) begin
            case (address)
               2'd0: e.rd[t][W-1:0] = m_stable;
               2'd1: e.rd[t][W-1:0] = m_s;
               2'd2: e.rd[t][W-1:0] = m_mask;
               default: e.rd[t][W-1:0] = m_cap[t];
            endcase
         end
         nstable = m_stable;
         for (int b = 0; b < int'(W); b++) begin
            win[b].push_back(m_s[b]);
            if (win[b].size() > int'(D)) void'(win[b].pop_front());
            if (win[b].size() == int'(D)) begin
               all_diff = 1'b1;
               foreach (win[b][k]) if (win[b][k] == m_stable[b]) all_diff = 1'b0;
               if (all_diff) begin
                  nstable[b] = ~m_stable[b];
                  win[b].delete();
               end
            end
         end
         rise = nstable & ~m_stable;
         fall = m_stable & ~nstable;
         clr  = (chipselect && write && address == 2'd3) ? writedata[W-1:0] : '0;
         m_cap[0] = (m_cap[0] & ~clr) | rise;
         m_cap[1] = (m_cap[1] & ~clr) | fall;
         m_cap[2] = (m_cap[2] & ~clr) | rise | fall;
         if (chipselect && write && address == 2'd2) m_mask = writedata[W-1:0];
         m_s      = m_p1;
         m_p1     = in_port ^ Inv;
         m_stable = nstable;
         for (int t = 0; t < 3; t++) e.irq[t] = |(m_cap[t] & m_mask);
      end
      exp_q.push_back(e);
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin : monitor
      exp_t e;
      cyc++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         for (int t = 0; t < 3; t++) begin
            checks++;
            if (readdata[t] !== e.rd[t]) begin
               errors++;
               if (errors < 30)
                  $display("FAIL readdata[edge_type=%0d] cycle %0d: got %h expected %h",
                           t, cyc, readdata[t], e.rd[t]);
            end
            checks++;
            if (irq[t] !== e.irq[t]) begin
               errors++;
               if (errors < 30)
                  $display("FAIL irq[edge_type=%0d] cycle %0d: got %b expected %b",
                           t, cyc, irq[t], e.irq[t]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cycles(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic set_in(input logic [W-1:0] v);
      in_port = v ^ Inv;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
      cycles(1);
      chipselect = 1'b0; write = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write = 1'b0;
      writedata = '0; in_port = Inv;
      cycles(3);
      reset_n = 1'b1;
      cycles(4);

      // Held press on bit0, then a 3-cycle glitch on bit2.
      address = 2'd0;
      set_in(4'b0001); cycles(10);
      address = 2'd3; cycles(2);
      set_in(4'b0101); cycles(3);
      set_in(4'b0001); address = 2'd0; cycles(10);

      // Mask gating and W1C clear.
      address = 2'd3; cycles(2);
      wr(2'd2, 32'h1); cycles(2);
      wr(2'd3, 32'h1); cycles(2);

      // Clear on the very edge a new bit0 rise is accepted.
      set_in(4'b0000); cycles(10);
      wr(2'd3, 32'hF);
      set_in(4'b0001); cycles(5);
      wr(2'd3, 32'h1); address = 2'd3; cycles(3);

      // Bit3 0->1->0, six cycles per level, watching raw.
      address = 2'd1;
      set_in(4'b1001); cycles(6);
      set_in(4'b0001); cycles(6);
      address = 2'd3; cycles(4);

      // Reset in the middle of a debounce, with an input already high.
      set_in(4'b0011); cycles(3);
      reset_n = 1'b0; cycles(2);
      reset_n = 1'b1; address = 2'd0; cycles(10);
      address = 2'd3; cycles(2);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         int hold;
         in_port = W'($urandom);
         hold = int'($urandom_range(1, 10));
         for (int c = 0; c < hold; c++) begin
            address    = 2'($urandom);
            writedata  = $urandom;
            chipselect = ($urandom_range(0, 3) != 0);
            write      = ($urandom_range(0, 7) == 0);
            cycles(1);
         end
         write = 1'b0; chipselect = 1'b0;
      end

      cycles(3);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pio_button_debounced.md
Name: pio_button_debounced

Overview:
Parametrised successor to the team's simple input PIO for push-buttons and switches on the Avalon-MM bus. Adds per-bit synchronisation, counter-based debounce, edge capture, an interrupt mask and a level IRQ to the Nios II interrupt controller. Width and debounce time are configurable. Register read timing is unchanged: registered readdata, updated every clock.

Parameters:
WIDTH, 4, number of input bits (1..32)
DEBOUNCE_CYCLES, 50000, consecutive clk cycles a synchronised input must differ from the debounced value before it is accepted (>=1)
EDGE_TYPE, 0, edge that sets capture bits: 0 rising, 1 falling, 2 any

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
address  in  2  Avalon word address
chipselect  in  1  slave select
write  in  1  write strobe, qualified by chipselect
writedata  in  32  write data
in_port  in  WIDTH  raw, asynchronous button inputs
readdata  out  32  registered read data
irq  out  1  level interrupt request

Behaviour:
- Reset is asynchronous and active-low, with clock clk. On reset, all registers clear to 0: sync stages, debounced value, counters, mask, edge capture, readdata. irq is 0.
- Synchroniser: two flops per bit, s = second stage. Raw input to s takes 2 edges.
- Debounce, per bit, with counter width clog2(DEBOUNCE_CYCLES+1):
  - If s == stable: counter <= 0.
  - Otherwise counter increments.
  - When the counter would reach DEBOUNCE_CYCLES: stable <= s and counter <= 0.
  - Any return of s to stable before then resets the counter, so glitches shorter than DEBOUNCE_CYCLES are rejected.
- Edge capture: on the same edge that stable changes, the bit sets if the transition matches EDGE_TYPE. It stays set until cleared.
- Register map (word addresses):
  - 0 data, RO: stable, zero-extended.
  - 1 raw, RO: s, zero-extended (diagnostic).
  - 2 irqmask, RW: bits [WIDTH-1:0].
  - 3 edgecapture, R/W1C.
  - Bits at and above WIDTH read 0. Writes to addresses 0 and 1 are ignored.
- Write: write && chipselect.
  - Address 2 loads mask <= writedata[WIDTH-1:0].
  - Address 3 clears each capture bit whose writedata bit is 1.
  - If a set and a clear hit the same bit on the same edge, the set wins.
- Read: readdata <= mux(address) every clock, independent of chipselect or read. Latency is 1 cycle, with no wait states.
- irq = |(edgecapture & mask). Combinational from registers only, never from in_port.
- Latency for an input held stable: a change before edge 0 gives the stable update at edge 1+DEBOUNCE_CYCLES. irq is high after that same edge. readdata at address 0 reflects it after edge 2+DEBOUNCE_CYCLES.
- Reset mid-debounce discards partial counts. After release, stable starts at 0, and an input already high is re-qualified as a new rising edge.

Optional Feature:
BUTTON_ACTIVE_LOW_EN.
- Defined: in_port is inverted before the synchroniser. This suits board keys that read 0 when pressed, so data bit 1 = pressed and rising = press. Immediately after reset, released keys (in_port = 1) read as stable 0 and create no capture.
- Undefined: in_port is used as is.
- The register map and timing are identical in both cases.

Test Plan:
- WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=0, in_port 0000->0001 held -> stable bit0 set at edge 5; address 0 readdata = 0x00000001 after edge 6; edgecapture = 0x1.
- Glitch on bit2: high for 3 cycles, then low -> data and edgecapture stay 0; counter returns to 0.
- Mask=0x0 with edge captured -> irq=0. Write mask 0x1 -> irq=1 next cycle. Write 0x1 to address 3 -> edgecapture=0 and irq=0.
- Clear written on the same edge a new bit0 rising edge is accepted -> edgecapture bit0 remains 1.
- EDGE_TYPE=2, bit3 goes 0->1->0 with each level held 6 cycles -> captured on both transitions; address 1 readdata shows raw s 2 cycles after each change.
- BUTTON_ACTIVE_LOW_EN defined, in_port=1111 through reset, then bit1 driven 0 -> data = 0x00000002 and edgecapture = 0x2; no capture at reset release.
